// File: rtl/tracker_query_arbiter_if.sv
// Requester-side bus of tracker_query_arbiter.
//   master : requester side (drives requests, consumes responses)
//   slave  : arbiter side (accepts requests, produces responses)
// Signals:
//   req_valid/req_ready   per-requester request handshake (ready is a grant pulse)
//   req_kind              0 = timing query, 1 = range query
//   req_value             look-back depth for a timing query
//   req_lo/req_hi         range bounds (signed) for a range query
//   rsp_valid/rsp_ready   per-requester response handshake
//   rsp_time              {start, end}, shared, qualified by rsp_valid
//   rsp_hit/rsp_err       query hit / request rejected
interface tracker_query_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_kind;
  logic [NUM_REQ-1:0][31:0] req_value;
  logic [NUM_REQ-1:0][31:0] req_lo;
  logic [NUM_REQ-1:0][31:0] req_hi;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [1:0][31:0]         rsp_time;
  logic                     rsp_hit;
  logic                     rsp_err;

  modport master (
    output req_valid, req_kind, req_value, req_lo, req_hi, rsp_ready,
    input  req_ready, rsp_valid, rsp_time, rsp_hit, rsp_err
  );

  modport slave (
    input  req_valid, req_kind, req_value, req_lo, req_hi, rsp_ready,
    output req_ready, rsp_valid, rsp_time, rsp_hit, rsp_err
  );
endinterface

// File: rtl/tracker_query_arbiter.sv
// tracker_query_arbiter: shares one signal_tracker query port pair among
// NUM_REQ requesters. Round-robin grant, drives the tracker's combinational
// query inputs from registers, waits SETTLE_CYCLES, captures the result and
// returns it on a per-requester valid/ready response channel.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             tracker_query_arbiter_if.slave (request/response bus)
//   trk_value       -> tracker value_in   (park value 0)
//   trk_range       -> tracker range_in   {lo, hi} (park value {1,0})
//   trk_time        <- tracker time_out   {start, end}, signed
//   trk_range_hit   <- tracker range_out
// Build option: define TRACKER_RANGE_QUERY_EN to support range queries;
// otherwise every range request is answered with rsp_err and trk_range is
// tied to its park value.
module tracker_query_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned BUFFER_WIDTH  = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tracker_query_arbiter_if.slave bus,
  output logic [31:0]            trk_value,
  output logic [1:0][31:0]       trk_range,
  input  logic [1:0][31:0]       trk_time,
  input  logic                   trk_range_hit
);
  localparam int unsigned      IDX_W      = $clog2(NUM_REQ);
  localparam int unsigned      CNT_W      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [1:0][31:0] PARK_RANGE = {32'd1, 32'd0};

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, CAPTURE, RESPOND, PARK} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]         g_q, g_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic [31:0]              value_q, value_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [1:0][31:0]         rsp_time_q, rsp_time_d;
  logic                     rsp_hit_q, rsp_hit_d;
  logic                     rsp_err_q, rsp_err_d;
  logic [31:0]              trk_value_q, trk_value_d;
`ifdef TRACKER_RANGE_QUERY_EN
  localparam logic [31:0]   MAX_IDX = 32'(BUFFER_WIDTH - 1);
  logic                     kind_q, kind_d;
  logic [31:0]              lo_q, lo_d, hi_q, hi_d;
  logic [1:0][31:0]         trk_range_q, trk_range_d;
`else
  logic                     unused_range_hit;
  assign unused_range_hit = trk_range_hit;
`endif

  logic                     found;
  logic [IDX_W-1:0]         gidx;
  logic [IDX_W-1:0]         cand;
  int unsigned              idx;
  logic                     req_bad;
  logic [NUM_REQ-1:0]       req_ready_c;

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDX_W'(idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  always_comb begin
    req_bad = 1'b0;
    if (bus.req_kind[gidx]) begin
`ifdef TRACKER_RANGE_QUERY_EN
      req_bad = ($signed(bus.req_hi[gidx]) < $signed(bus.req_lo[gidx])) ||
                bus.req_lo[gidx][31] ||
                ($signed(bus.req_hi[gidx]) > $signed(MAX_IDX));
`else
      req_bad = 1'b1;
`endif
    end else begin
      req_bad = (bus.req_value[gidx] == '0) || (bus.req_value[gidx] > BUFFER_WIDTH);
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    g_d         = g_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    value_d     = value_q;
    rsp_valid_d = rsp_valid_q;
    rsp_time_d  = rsp_time_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_err_d   = rsp_err_q;
    trk_value_d = trk_value_q;
`ifdef TRACKER_RANGE_QUERY_EN
    kind_d      = kind_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    trk_range_d = trk_range_q;
`endif
    req_ready_c = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_c[gidx] = 1'b1;
          g_d     = gidx;
          value_d = bus.req_value[gidx];
          err_d   = req_bad;
`ifdef TRACKER_RANGE_QUERY_EN
          kind_d  = bus.req_kind[gidx];
          lo_d    = bus.req_lo[gidx];
          hi_d    = bus.req_hi[gidx];
`endif
          // Rejected requests skip the tracker; CAPTURE builds the error
          // response so rsp_valid rises one edge after the grant.
          state_d = req_bad ? CAPTURE : ISSUE;
        end
      end
      ISSUE: begin
`ifdef TRACKER_RANGE_QUERY_EN
        if (kind_q) trk_range_d = {lo_q, hi_q};
        else        trk_value_d = value_q;
`else
        trk_value_d = value_q;
`endif
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      CAPTURE: begin
        rsp_valid_d      = '0;
        rsp_valid_d[g_q] = 1'b1;
        if (err_q) begin
          rsp_time_d = '1;
          rsp_hit_d  = 1'b0;
          rsp_err_d  = 1'b1;
        end else begin
          rsp_time_d = trk_time;
          rsp_err_d  = 1'b0;
`ifdef TRACKER_RANGE_QUERY_EN
          rsp_hit_d  = kind_q ? trk_range_hit : (trk_time[1] != '1);
`else
          rsp_hit_d  = (trk_time[1] != '1);
`endif
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        if (bus.rsp_ready[g_q]) begin
          rsp_valid_d = '0;
          rr_ptr_d    = (32'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
          // Park registered now so the values are on the tracker during PARK.
          trk_value_d = '0;
`ifdef TRACKER_RANGE_QUERY_EN
          trk_range_d = PARK_RANGE;
`endif
          state_d     = PARK;
        end
      end
      PARK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      g_q         <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      value_q     <= '0;
      rsp_valid_q <= '0;
      rsp_time_q  <= '1;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      trk_value_q <= '0;
`ifdef TRACKER_RANGE_QUERY_EN
      kind_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      trk_range_q <= PARK_RANGE;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      g_q         <= g_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      value_q     <= value_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_time_q  <= rsp_time_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_err_q   <= rsp_err_d;
      trk_value_q <= trk_value_d;
`ifdef TRACKER_RANGE_QUERY_EN
      kind_q      <= kind_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      trk_range_q <= trk_range_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_time  = rsp_time_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_err   = rsp_err_q;
  assign trk_value     = trk_value_q;
`ifdef TRACKER_RANGE_QUERY_EN
  assign trk_range     = trk_range_q;
`else
  assign trk_range     = PARK_RANGE;
`endif
endmodule

// File: tb/tb_tracker_query_arbiter.sv
// Directed bench for tracker_query_arbiter (NUM_REQ=4, BUFFER_WIDTH=8,
// SETTLE_CYCLES=1) with a combinational tracker stub.
module tb_tracker_query_arbiter;
  localparam int unsigned NR = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned SC = 1;
  localparam logic [63:0] PARK = {32'd1, 32'd0};
  localparam logic [63:0] NEG  = {32'hFFFF_FFFF, 32'hFFFF_FFFF};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      trk_value;
  logic [1:0][31:0] trk_range;
  logic [1:0][31:0] trk_time;
  logic             trk_range_hit;
  int               n_checks = 0;
  int               n_fail = 0;

  always #5 clk = ~clk;

  tracker_query_arbiter_if #(.NUM_REQ(NR)) bus ();

  tracker_query_arbiter #(
    .NUM_REQ(NR),
    .BUFFER_WIDTH(BW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .trk_value(trk_value),
    .trk_range(trk_range),
    .trk_time(trk_time),
    .trk_range_hit(trk_range_hit)
  );

  // Tracker stub: value 0 or 7 -> {-1,-1}, else {v+6, v+8};
  // range hit when hi-lo == 2.
  always_comb begin
    if (trk_value == 32'd0 || trk_value == 32'd7) trk_time = NEG;
    else trk_time = {trk_value + 32'd6, trk_value + 32'd8};
    trk_range_hit = (($signed(trk_range[0]) - $signed(trk_range[1])) == 32'sd2);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge with the DUT idle; returns just after a posedge.
  task automatic run_q(input string tag, input int i, input logic kind,
                       input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi,
                       input int exp_lat, input logic [63:0] exp_time,
                       input logic exp_hit, input logic exp_err, input int hold,
                       output logic [31:0] tv, output logic [63:0] tr, output logic pk);
    logic [NR-1:0] oh;
    logic [NR-1:0] gv;
    int k;
    int bad_v;
    int bad_t;
    int bad_r;
    oh = '0;
    oh[i] = 1'b1;
    gv = '0;
    k = 0;
    tv = '0;
    tr = '0;
    pk = 1'b1;
    bus.req_kind[i]  = kind;
    bus.req_value[i] = v;
    bus.req_lo[i]    = lo;
    bus.req_hi[i]    = hi;
    bus.req_valid[i] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        gv = bus.req_ready;
        break;
      end
    end
    check({tag, "_grant"}, gv, oh);
    @(posedge clk);
    #1 bus.req_valid[i] = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (n == 2) begin
        tv = trk_value;
        tr = trk_range;
      end
      if (trk_value != 32'd0 || trk_range != PARK) pk = 1'b0;
      if (bus.rsp_valid[i]) begin
        k = n;
        break;
      end
    end
    check({tag, "_lat"}, 64'(k - 1), 64'(exp_lat));
    check({tag, "_valid"}, bus.rsp_valid, oh);
    check({tag, "_time"}, bus.rsp_time, exp_time);
    check({tag, "_hit"}, bus.rsp_hit, exp_hit);
    check({tag, "_err"}, bus.rsp_err, exp_err);
    bad_v = 0;
    bad_t = 0;
    bad_r = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (bus.rsp_valid != oh) bad_v++;
      if (bus.rsp_time != exp_time) bad_t++;
      if (bus.req_ready != '0) bad_r++;
    end
    if (hold > 0) begin
      check({tag, "_hold_valid"}, 64'(bad_v), 0);
      check({tag, "_hold_time"}, 64'(bad_t), 0);
      check({tag, "_hold_noready"}, 64'(bad_r), 0);
    end
    bus.rsp_ready[i] = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready[i] = 1'b0;
    @(negedge clk);
    check({tag, "_consumed"}, bus.rsp_valid, 0);
    check({tag, "_parked"}, {trk_value, trk_range}, {32'd0, PARK});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] tv;
    logic [63:0] tr;
    logic        pk;
    logic        g;
    int          order[5];
    int          exp_order[5];
    int          ng;
    int          overlap;
    exp_order = '{0, 1, 2, 3, 0};

    bus.req_valid = '0;
    bus.req_kind  = '0;
    bus.req_value = '0;
    bus.req_lo    = '0;
    bus.req_hi    = '0;
    bus.rsp_ready = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_time", bus.rsp_time, NEG);
    check("rst_rsp_hit", bus.rsp_hit, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_trk_value", trk_value, 0);
    check("rst_trk_range", trk_range, PARK);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Timing queries
    run_q("t3", 0, 1'b0, 32'd3, 0, 0, 2 + SC, {32'd9, 32'd11}, 1'b1, 1'b0, 0, tv, tr, pk);
    check("t3_trk_value", tv, 3);
    check("t3_trk_range", tr, PARK);
    run_q("t7", 1, 1'b0, 32'd7, 0, 0, 2 + SC, NEG, 1'b0, 1'b0, 0, tv, tr, pk);
    run_q("t8", 2, 1'b0, 32'd8, 0, 0, 2 + SC, {32'd14, 32'd16}, 1'b1, 1'b0, 0, tv, tr, pk);
    check("t8_trk_value", tv, 8);

    // Rejected timing queries
    run_q("v0", 3, 1'b0, 32'd0, 0, 0, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("v0_parked_all", pk, 1);
    run_q("v9", 1, 1'b0, 32'd9, 0, 0, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("v9_parked_all", pk, 1);

`ifdef TRACKER_RANGE_QUERY_EN
    run_q("r24a", 1, 1'b1, 0, 32'd2, 32'd4, 2 + SC, NEG, 1'b1, 1'b0, 0, tv, tr, pk);
    check("r24a_trk_range", tr, {32'd2, 32'd4});
    check("r24a_trk_value", tv, 0);
    run_q("r24b", 1, 1'b1, 0, 32'd2, 32'd4, 2 + SC, NEG, 1'b1, 1'b0, 0, tv, tr, pk);
    check("r24b_trk_range", tr, {32'd2, 32'd4});
    run_q("r12", 3, 1'b1, 0, 32'd1, 32'd2, 2 + SC, NEG, 1'b0, 1'b0, 0, tv, tr, pk);
    check("r12_trk_range", tr, {32'd1, 32'd2});
    run_q("r53", 1, 1'b1, 0, 32'd5, 32'd3, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("r53_parked_all", pk, 1);
    run_q("r08", 0, 1'b1, 0, 32'd0, 32'd8, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("r08_parked_all", pk, 1);
    run_q("rneg", 2, 1'b1, 0, 32'hFFFF_FFFF, 32'd2, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("rneg_parked_all", pk, 1);
`else
    run_q("r24x", 1, 1'b1, 0, 32'd2, 32'd4, 1, NEG, 1'b0, 1'b1, 0, tv, tr, pk);
    check("r24x_parked_all", pk, 1);
`endif

    // Reset during SETTLE
    g = 1'b0;
    bus.req_kind[2]  = 1'b0;
    bus.req_value[2] = 32'd3;
    bus.req_valid[2] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin
        g = 1'b1;
        break;
      end
    end
    check("rmid_grant", g, 1);
    @(posedge clk);
    #1 bus.req_valid[2] = 1'b0;
    @(posedge clk);
    #1 check("rmid_pre_trk_value", trk_value, 3);
    rst_n = 1'b0;
    #1;
    check("rmid_req_ready", bus.req_ready, 0);
    check("rmid_rsp_valid", bus.rsp_valid, 0);
    check("rmid_rsp_time", bus.rsp_time, NEG);
    check("rmid_rsp_hit", bus.rsp_hit, 0);
    check("rmid_rsp_err", bus.rsp_err, 0);
    check("rmid_trk_value", trk_value, 0);
    check("rmid_trk_range", trk_range, PARK);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rmid_no_rsp", bus.rsp_valid, 0);

    // Round-robin with all requesters continuously valid
    @(posedge clk);
    #1;
    for (int j = 0; j < NR; j++) begin
      bus.req_kind[j]  = 1'b0;
      bus.req_value[j] = 32'(j + 1);
    end
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    ng = 0;
    overlap = 0;
    for (int n = 0; n < 200 && ng < 5; n++) begin
      @(negedge clk);
      if ($countones(bus.req_ready) > 1) overlap++;
      if (bus.req_ready != '0) begin
        for (int j = 0; j < NR; j++) if (bus.req_ready[j]) order[ng] = j;
        ng++;
      end
    end
    @(posedge clk);
    #1 bus.req_valid = '0;
    repeat (8) @(posedge clk);
    #1 bus.rsp_ready = '0;
    check("rr_count", 64'(ng), 5);
    check("rr_overlap", 64'(overlap), 0);
    for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), 64'(order[k]), 64'(exp_order[k]));

    // Backpressure on requester 2 while requester 0 waits
    bus.req_kind[0]  = 1'b0;
    bus.req_value[0] = 32'd5;
    bus.req_valid[0] = 1'b1;
    bus.rsp_ready[0] = 1'b1;
    run_q("bp2", 2, 1'b0, 32'd4, 0, 0, 2 + SC, {32'd10, 32'd12}, 1'b1, 1'b0, 10, tv, tr, pk);
    run_q("bp0", 0, 1'b0, 32'd5, 0, 0, 2 + SC, {32'd11, 32'd13}, 1'b1, 1'b0, 0, tv, tr, pk);
    bus.rsp_ready = '0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
